alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one `alu` instance between two requesters: port 0 is the EX stage and port 1 is the coprocessor/address-generation path. The block accepts one operation at a time through a valid/ready handshake and chooses between ports by round-robin. It registers operands, runs the ALU for one cycle and holds the registered result until the owning requester acknowledges it. It sits in `exu` beside `alu` and replaces direct operand muxing.

Parameters:
DATA_W, 32, operand/result width; must equal the `alu` width (`WordDataBus`).
OP_W, 4, ALU opcode width (`ALU_OP_*` encodings).
RSP_TIMEOUT, 0, cycles a response may wait for ack before being dropped; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-high
req_0_valid / req_1_valid  in  1  requester has an operation pending
req_0_op / req_1_op  in  OP_W  ALU opcode
req_0_in_0 / req_1_in_0  in  DATA_W  operand 0
req_0_in_1 / req_1_in_1  in  DATA_W  operand 1
req_0_ready / req_1_ready  out  1  combinational accept strobe; the operation is taken in this cycle
rsp_0_valid / rsp_1_valid  out  1  result available for that port
rsp_out  out  DATA_W  result (shared bus; qualified by rsp_x_valid)
rsp_of  out  1  overflow flag from the ALU
rsp_0_ack / rsp_1_ack  in  1  requester consumes the result
busy  out  1  state is not IDLE
timeout  out  1  one-cycle pulse when a response is dropped

Behaviour:
- One clock and one reset only; reset is synchronous and active-high. Use `ENABLE` / `DISABLE` for 1-bit levels.
- Reset values: all ready and valid outputs 0; rsp_out 0; rsp_of 0; busy 0; timeout 0; state IDLE; last_grant 1, so port 0 wins the first tie.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, neither port valid: stay in IDLE.
- IDLE, one port valid: grant that port; its req_x_ready = 1 in the same cycle.
- IDLE, both ports valid: grant the port != last_grant.
- On grant: capture op/in_0/in_1 into operand registers, record the owner, update last_grant, go to EXEC. Exactly one ready may be high, and only in IDLE.
- EXEC: the ALU is driven from the registered operands. At the clock edge, capture out/of into rsp_out/rsp_of, then go to RESP.
- RESP: rsp_owner_valid = 1 and rsp_out/rsp_of stay stable until rsp_owner_ack is sampled high. Then go to IDLE with valid deasserted.
- Ack on the non-owner port is ignored. Ack asserted during IDLE or EXEC is ignored.
- Latency: accept at cycle N gives rsp_valid from cycle N+2. Minimum issue interval is 3 cycles, since the ack cycle returns to IDLE before the next grant.
- Timeout: with RSP_TIMEOUT > 0, a counter runs in RESP. After RSP_TIMEOUT cycles without ack, return to IDLE, deassert valid and pulse timeout for one cycle. The counter clears on entering RESP.
- Requester valids may drop while not granted; nothing is latched for an ungranted port.
- Reset mid-operation (EXEC or RESP): the pending result is discarded and no rsp_valid is produced afterward.
- Arithmetic and overflow rules are exactly those of `alu`. ADDS/SUBS give signed overflow; all other ops give of = 0. Shift amount comes from in_1[`ShAmountLoc`].

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority; port 0 always wins when both ports are valid, and last_grant is unused.
- Undefined: round-robin as specified above.

Decomposition:
- Shared header (alongside cpu.h): FSM state encodings for IDLE/EXEC/RESP, the port-ID constants, and the reuse of `ALU_OP_*` and `WordDataBus`.
- One sub-module: the existing `alu`, instantiated once and fed from the operand registers. Grant logic stays inline.

Test Plan:
1. Port 0 only, op=`ALU_OP_ADDU`, 5+7 accepted at cycle 10 -> req_0_ready=1 at cycle 10; rsp_0_valid=1 from cycle 12 with rsp_out=12, rsp_of=0; ack at cycle 14 -> valid=0 at cycle 15.
2. Both valid every cycle, all ops ADDU, acked immediately -> grants alternate 0,1,0,1 with port 0 first after reset; no port starves; rsp_1_valid never high for a port-0 operation.
3. Port 1, `ALU_OP_ADDS`, 0x7FFFFFFF + 0x00000001 -> rsp_out=0x80000000, rsp_of=1. Also `ALU_OP_SUBU`, 0 - 1 -> 0xFFFFFFFF, rsp_of=0.
4. RSP_TIMEOUT=4 and no ack -> rsp_0_valid high for exactly 4 cycles, timeout pulses once, busy=0 afterwards, and the next request is accepted.
5. Reset asserted during EXEC -> next cycle: all outputs at reset values, no response for the discarded operation. With ALU_ARB_FIXED_PRIO_EN defined and both ports valid, port 0 wins every grant.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared definitions for the ALU arbiter.
// FSM state encodings, requester port IDs, ALU opcode encodings,
// word width and the 1-bit level names used by the arbiter and its ALU.
package alu_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Word data bus width (WordDataBus)
  localparam int WORD_DATA_W = 32;

  // ALU opcodes (ALU_OP_*)
  localparam int ALU_OP_W = 4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDS = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBS = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHRL = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'h9;

  // Shift amount field inside operand 1 (ShAmountLoc)
  localparam int SH_AMOUNT_MSB = 4;
  localparam int SH_AMOUNT_LSB = 0;
  localparam int SH_AMOUNT_W   = SH_AMOUNT_MSB - SH_AMOUNT_LSB + 1;

  // Requester port IDs
  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: the shared single-cycle ALU. Logic, add/sub and
// logical shifts; only ADDS/SUBS report signed overflow.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = WORD_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  output logic [DATA_W-1:0] out,
  output logic              of
);

  logic [DATA_W-1:0]      sum_s;
  logic [DATA_W-1:0]      diff_s;
  logic [SH_AMOUNT_W-1:0] sh_amt_s;

  assign sum_s    = in_0 + in_1;
  assign diff_s   = in_0 - in_1;
  assign sh_amt_s = in_1[SH_AMOUNT_MSB:SH_AMOUNT_LSB];

  // Opcode decode: result word and signed-overflow flag
  always_comb begin
    out = in_0;
    of  = DISABLE;
    case (op)
      ALU_OP_AND:  out = in_0 & in_1;
      ALU_OP_OR:   out = in_0 | in_1;
      ALU_OP_XOR:  out = in_0 ^ in_1;
      ALU_OP_ADDS: begin
        out = sum_s;
        of  = (in_0[DATA_W-1] == in_1[DATA_W-1]) &&
              (sum_s[DATA_W-1] != in_0[DATA_W-1]);
      end
      ALU_OP_ADDU: out = sum_s;
      ALU_OP_SUBS: begin
        out = diff_s;
        of  = (in_0[DATA_W-1] != in_1[DATA_W-1]) &&
              (diff_s[DATA_W-1] != in_0[DATA_W-1]);
      end
      ALU_OP_SUBU: out = diff_s;
      ALU_OP_SHRL: out = in_0 >> sh_amt_s;
      ALU_OP_SHLL: out = in_0 << sh_amt_s;
      default: begin
        out = in_0;
        of  = DISABLE;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the EX stage (port 0) and the
// coprocessor/address-generation path (port 1). One operation in flight:
// IDLE grants, EXEC runs the ALU on registered operands, RESP holds the
// result until the owner acks (or RSP_TIMEOUT expires, if nonzero).
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0
// wins ties); otherwise ties are resolved round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W      = WORD_DATA_W,
  parameter int OP_W        = ALU_OP_W,
  parameter int RSP_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0_valid,
  input  logic [OP_W-1:0]   req_0_op,
  input  logic [DATA_W-1:0] req_0_in_0,
  input  logic [DATA_W-1:0] req_0_in_1,
  output logic              req_0_ready,
  input  logic              req_1_valid,
  input  logic [OP_W-1:0]   req_1_op,
  input  logic [DATA_W-1:0] req_1_in_0,
  input  logic [DATA_W-1:0] req_1_in_1,
  output logic              req_1_ready,
  output logic              rsp_0_valid,
  output logic              rsp_1_valid,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_of,
  input  logic              rsp_0_ack,
  input  logic              rsp_1_ack,
  output logic              busy,
  output logic              timeout
);

  arb_state_e        state_r, state_s;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] in_0_r, in_1_r;
  logic              owner_r;
  logic              grant_s, grant_port_s, tie_port_s;
  logic              owner_ack_s, timeout_hit_s, timeout_evt_s;
  logic [DATA_W-1:0] alu_out_s;
  logic              alu_of_s;
  logic              rsp_0_valid_r, rsp_1_valid_r, rsp_of_r, busy_r, timeout_r;
  logic [DATA_W-1:0] rsp_out_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant_r;

  // Remember the latest winner so a tie goes to the other port
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= PORT_1;
    end else if (grant_s) begin
      last_grant_r <= grant_port_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign tie_port_s = (last_grant_r == PORT_0) ? PORT_1 : PORT_0;
`else
  assign tie_port_s = PORT_0;
`endif

  // Grant decision: only in IDLE and never while reset is asserted
  always_comb begin
    grant_s      = DISABLE;
    grant_port_s = PORT_0;
    if (!reset && (state_r == ST_IDLE)) begin
      if (req_0_valid && req_1_valid) begin
        grant_s      = ENABLE;
        grant_port_s = tie_port_s;
      end else if (req_0_valid) begin
        grant_s      = ENABLE;
        grant_port_s = PORT_0;
      end else if (req_1_valid) begin
        grant_s      = ENABLE;
        grant_port_s = PORT_1;
      end else begin
        grant_s      = DISABLE;
        grant_port_s = PORT_0;
      end
    end else begin
      grant_s      = DISABLE;
      grant_port_s = PORT_0;
    end
  end

  assign req_0_ready = grant_s && (grant_port_s == PORT_0);
  assign req_1_ready = grant_s && (grant_port_s == PORT_1);
  assign owner_ack_s = (owner_r == PORT_0) ? rsp_0_ack : rsp_1_ack;

  generate
    if (RSP_TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
      logic [CNT_W-1:0] cnt_r;

      // Count cycles spent in RESP; restarts every time RESP is entered
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_RESP) begin
          cnt_r <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end

      assign timeout_hit_s = (state_r == ST_RESP) &&
                             (cnt_r == CNT_W'(RSP_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit_s = DISABLE;
    end
  endgenerate

  // Next-state logic; an ack in the same cycle as expiry wins
  always_comb begin
    state_s       = state_r;
    timeout_evt_s = DISABLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_s = ST_EXEC;
        else         state_s = ST_IDLE;
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (owner_ack_s) begin
          state_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          state_s       = ST_IDLE;
          timeout_evt_s = ENABLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, operand capture, result capture and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      op_r          <= {OP_W{1'b0}};
      in_0_r        <= {DATA_W{1'b0}};
      in_1_r        <= {DATA_W{1'b0}};
      owner_r       <= PORT_0;
      rsp_0_valid_r <= DISABLE;
      rsp_1_valid_r <= DISABLE;
      rsp_out_r     <= {DATA_W{1'b0}};
      rsp_of_r      <= DISABLE;
      busy_r        <= DISABLE;
      timeout_r     <= DISABLE;
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s != ST_IDLE);
      timeout_r     <= timeout_evt_s;
      rsp_0_valid_r <= (state_s == ST_RESP) && (owner_r == PORT_0);
      rsp_1_valid_r <= (state_s == ST_RESP) && (owner_r == PORT_1);
      if (grant_s) begin
        op_r    <= (grant_port_s == PORT_0) ? req_0_op   : req_1_op;
        in_0_r  <= (grant_port_s == PORT_0) ? req_0_in_0 : req_1_in_0;
        in_1_r  <= (grant_port_s == PORT_0) ? req_0_in_1 : req_1_in_1;
        owner_r <= grant_port_s;
      end
      if (state_r == ST_EXEC) begin
        rsp_out_r <= alu_out_s;
        rsp_of_r  <= alu_of_s;
      end
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op   (op_r),
    .in_0 (in_0_r),
    .in_1 (in_1_r),
    .out  (alu_out_s),
    .of   (alu_of_s)
  );

  assign rsp_0_valid = rsp_0_valid_r;
  assign rsp_1_valid = rsp_1_valid_r;
  assign rsp_out     = rsp_out_r;
  assign rsp_of      = rsp_of_r;
  assign busy        = busy_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_0_valid = 1'b0, req_1_valid = 1'b0;
  logic [OW-1:0] req_0_op = 4'h0, req_1_op = 4'h0;
  logic [DW-1:0] req_0_in_0 = 32'h0, req_0_in_1 = 32'h0;
  logic [DW-1:0] req_1_in_0 = 32'h0, req_1_in_1 = 32'h0;
  logic          req_0_ready, req_1_ready, rsp_0_valid, rsp_1_valid;
  logic [DW-1:0] rsp_out;
  logic          rsp_of, rsp_0_ack, rsp_1_ack, busy, timeout;
  logic          auto_ack = 1'b0, ack_0_man = 1'b0, ack_1_man = 1'b0;

  assign rsp_0_ack = ack_0_man | (auto_ack & rsp_0_valid);
  assign rsp_1_ack = ack_1_man | (auto_ack & rsp_1_valid);

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] out;
    logic          of;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_0 = 1'b0, prev_1 = 1'b0;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_0_valid(req_0_valid), .req_0_op(req_0_op),
    .req_0_in_0(req_0_in_0), .req_0_in_1(req_0_in_1), .req_0_ready(req_0_ready),
    .req_1_valid(req_1_valid), .req_1_op(req_1_op),
    .req_1_in_0(req_1_in_0), .req_1_in_1(req_1_in_1), .req_1_ready(req_1_ready),
    .rsp_0_valid(rsp_0_valid), .rsp_1_valid(rsp_1_valid),
    .rsp_out(rsp_out), .rsp_of(rsp_of),
    .rsp_0_ack(rsp_0_ack), .rsp_1_ack(rsp_1_ack),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each new response against the scoreboard head
  always @(negedge clk) begin
    if (rsp_0_valid || rsp_1_valid)
      check("valid_onehot", 64'(rsp_0_valid & rsp_1_valid), 64'd0);
    if ((rsp_0_valid && !prev_0) || (rsp_1_valid && !prev_1)) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_port",  64'(rsp_1_valid), 64'(mon_e.port));
        check("rsp_out",   64'(rsp_out),     64'(mon_e.out));
        check("rsp_of",    64'(rsp_of),      64'(mon_e.of));
        check("rsp_cycle", 64'(cyc),         64'(mon_e.cyc));
      end
    end
    prev_0 <= rsp_0_valid;
    prev_1 <= rsp_1_valid;
  end

  task automatic drive_port(input logic port, input logic v, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (port == PORT_0) begin
      req_0_valid = v; req_0_op = op; req_0_in_0 = a; req_0_in_1 = b;
    end else begin
      req_1_valid = v; req_1_op = op; req_1_in_0 = a; req_1_in_1 = b;
    end
  endtask

  task automatic wait_neg(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Present one request, wait (bounded) for its ready, queue the expectation
  task automatic issue(input logic port, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic eof,
                       input bit expect_rsp, output int acc);
    bit got = 1'b0;
    @(posedge clk); #1;
    drive_port(port, 1'b1, op, a, b);
    acc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == PORT_0) ? req_0_ready : req_1_ready) got = 1'b1;
    end
    check("accept", 64'(got), 64'd1);
    if (got) begin
      acc = cyc;
      check("ready_other", 64'((port == PORT_0) ? req_1_ready : req_0_ready), 64'd0);
      if (expect_rsp) exp_q.push_back('{port, eo, eof, cyc + 2});
    end
    @(posedge clk); #1;
    drive_port(port, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  acc;
    int  vcnt, tcnt, tcyc;
    bit  got;
    logic exp_port;

    // Reset state, with a request pending that must not be accepted
    req_0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 64'(req_0_ready), 64'd0);
    check("rst_valid",  64'({rsp_0_valid, rsp_1_valid}), 64'd0);
    check("rst_out",    64'(rsp_out), 64'd0);
    check("rst_flags",  64'({rsp_of, busy, timeout}), 64'd0);
    req_0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 1: port 0 ADDU 5+7, manual ack three cycles into RESP
    issue(PORT_0, ALU_OP_ADDU, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1, acc);
    wait_neg(acc + 1);
    check("t1_exec_valid", 64'(rsp_0_valid), 64'd0);
    check("t1_exec_busy",  64'(busy), 64'd1);
    wait_neg(acc + 3);
    ack_1_man = 1'b1;
    wait_neg(acc + 4);
    ack_1_man = 1'b0;
    check("t1_nonowner_ack", 64'(rsp_0_valid), 64'd1);
    check("t1_hold_out",     64'(rsp_out), 64'd12);
    ack_0_man = 1'b1;
    wait_neg(acc + 5);
    ack_0_man = 1'b0;
    check("t1_after_ack_valid", 64'(rsp_0_valid), 64'd0);
    check("t1_after_ack_busy",  64'(busy), 64'd0);

    // Test 2: both ports valid continuously, immediate ack
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    auto_ack = 1'b1;
    drive_port(PORT_0, 1'b1, ALU_OP_ADDU, 32'd100, 32'd1);
    drive_port(PORT_1, 1'b1, ALU_OP_ADDU, 32'd200, 32'd2);
    exp_port = PORT_0;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (req_0_ready || req_1_ready) got = 1'b1;
      end
      check("t2_grant_seen", 64'(got), 64'd1);
      if (got) begin
        check("t2_ready_onehot", 64'(req_0_ready & req_1_ready), 64'd0);
        check("t2_rr_port", 64'(req_1_ready), 64'(exp_port));
        exp_q.push_back('{exp_port, (exp_port == PORT_0) ? 32'd101 : 32'd202, 1'b0, cyc + 2});
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      exp_port = ~exp_port;
`endif
    end
    @(posedge clk); #1;
    drive_port(PORT_0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_port(PORT_1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);

    // Test 3: arithmetic, overflow and shift vectors
    issue(PORT_1, ALU_OP_ADDS, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b1, acc);
    issue(PORT_1, ALU_OP_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, acc);
    issue(PORT_0, ALU_OP_SUBS, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, acc);
    issue(PORT_1, ALU_OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, acc);
    issue(PORT_0, ALU_OP_ADDS, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 1'b0, 1'b1, acc);
    issue(PORT_1, ALU_OP_SHLL, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b1, acc);
    issue(PORT_0, ALU_OP_SHRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b1, acc);
    issue(PORT_1, ALU_OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, acc);
    issue(PORT_0, ALU_OP_AND,  32'h0000FF00, 32'h00000FF0, 32'h00000F00, 1'b0, 1'b1, acc);
    issue(PORT_1, ALU_OP_OR,   32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b1, acc);
    repeat (4) @(posedge clk);

    // Test 4: no ack, response dropped after TO cycles
    auto_ack = 1'b0;
    issue(PORT_0, ALU_OP_ADDU, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1, acc);
    vcnt = 0; tcnt = 0; tcyc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_0_valid) vcnt++;
      if (timeout) begin
        tcnt++;
        tcyc = cyc;
      end
    end
    check("t4_valid_cycles", 64'(vcnt), 64'(TO));
    check("t4_timeout_pulses", 64'(tcnt), 64'd1);
    check("t4_timeout_cycle", 64'(tcyc), 64'(acc + 2 + TO));
    check("t4_busy_after", 64'(busy), 64'd0);
    auto_ack = 1'b1;
    issue(PORT_1, ALU_OP_ADDU, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1, acc);
    repeat (4) @(posedge clk);

    // Test 5: reset during EXEC discards the operation
    issue(PORT_0, ALU_OP_ADDU, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0, acc);
    reset = 1'b1;
    req_0_valid = 1'b1;
    @(negedge clk);
    check("t5_exec_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t5_rst_ready", 64'({req_0_ready, req_1_ready}), 64'd0);
    check("t5_rst_valid", 64'({rsp_0_valid, rsp_1_valid}), 64'd0);
    check("t5_rst_out",   64'(rsp_out), 64'd0);
    check("t5_rst_flags", 64'({rsp_of, busy, timeout}), 64'd0);
    req_0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_no_rsp", 64'({rsp_0_valid, rsp_1_valid, busy}), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
